// File: rtl/combat_referee.sv
// Combat referee: per-frame hitbox/hurtbox resolution, health ownership and round sequencing.
// Stun loads and state updates land one clk after the evaluating frame_tick; no backpressure, no stall path.
module combat_referee #(
    parameter logic [6:0] HEALTH_MAX       = 7'd100,
    parameter logic [6:0] DMG_BASIC        = 7'd10,
    parameter logic [6:0] DMG_DIR          = 7'd15,
    parameter logic [4:0] HITSTUN_FRAMES   = 5'd15,
    parameter logic [4:0] BLOCKSTUN_FRAMES = 5'd8,
    parameter logic [7:0] COUNTDOWN_TICKS  = 8'd180,
    parameter logic [6:0] ROUND_SECONDS    = 7'd99,
    parameter logic [5:0] TICKS_PER_SEC    = 6'd60,
    parameter logic [7:0] HOLD_TICKS       = 8'd120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick_i,
    input  logic       start_i,
    input  logic [9:0] p1_x_i,
    input  logic [9:0] p2_x_i,
    input  logic [3:0] p1_state_i,
    input  logic [3:0] p2_state_i,
    input  logic       p1_block_i,
    input  logic       p2_block_i,
    output logic       p1_stun_load_o,
    output logic       p2_stun_load_o,
    output logic       p1_stun_block_o,
    output logic       p2_stun_block_o,
    output logic [4:0] p1_stun_frames_o,
    output logic [4:0] p2_stun_frames_o,
    output logic [6:0] p1_health_o,
    output logic [6:0] p2_health_o,
    output logic [6:0] timer_sec_o,
    output logic [2:0] round_state_o,
    output logic [1:0] winner_o,
    output logic       fight_en_o
);

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_FIGHT     = 3'd2,
        ST_KO        = 3'd3,
        ST_TIMEUP    = 3'd4,
        ST_RESULT    = 3'd5
    } state_t;

    localparam logic [7:0] CD_LAST   = COUNTDOWN_TICKS - 8'd1;
    localparam logic [7:0] SEC_LAST  = {2'b00, TICKS_PER_SEC} - 8'd1;
    localparam logic [7:0] HOLD_LAST = HOLD_TICKS - 8'd1;

    function automatic logic [6:0] sat_sub(input logic [6:0] hp, input logic [6:0] dmg);
        return (hp > dmg) ? (hp - dmg) : 7'd0;
    endfunction

    function automatic logic is_attack(input logic [3:0] s);
        return (s == 4'd4) || (s == 4'd7);
    endfunction

    // Block only holds from neutral or while already in blockstun.
    function automatic logic can_guard(input logic [3:0] s, input logic blk);
        return blk && ((s == 4'd0) || (s == 4'd1) || (s == 4'd2) || (s == 4'd10));
    endfunction

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [6:0] p1_hp_q, p1_hp_d, p2_hp_q, p2_hp_d;
    logic [6:0] timer_q, timer_d;
    logic [1:0] winner_q, winner_d;
    logic       p1_hit_q, p1_hit_d, p2_hit_q, p2_hit_d;
    logic       p1_load_q, p1_load_d, p2_load_q, p2_load_d;
    logic       p1_blk_q, p1_blk_d, p2_blk_q, p2_blk_d;
    logic [4:0] p1_frm_q, p1_frm_d, p2_frm_q, p2_frm_d;

    // 11-bit geometry so sprites near the right edge never wrap.
    logic [10:0] x1, x2;
    logic        p1_reach, p2_reach;
    assign x1       = {1'b0, p1_x_i};
    assign x2       = {1'b0, p2_x_i};
    assign p1_reach = (x1 + 11'd45 < x2 + 11'd44) && (x2 + 11'd20 < x1 + 11'd58);
    assign p2_reach = (x2 + 11'd6 < x1 + 11'd44) && (x1 + 11'd20 < x2 + 11'd19);

    logic       eval, p1_conn, p2_conn, trade, p1_blocked, p2_blocked;
    logic [6:0] p1_dmg, p2_dmg, p1_hp_hit, p2_hp_hit;

    assign eval       = frame_tick_i && (state_q == ST_FIGHT);
    assign p1_conn    = eval && is_attack(p1_state_i) && p1_reach && !p1_hit_q;
    assign p2_conn    = eval && is_attack(p2_state_i) && p2_reach && !p2_hit_q;
    assign trade      = p1_conn && p2_conn;
    assign p2_blocked = p1_conn && !trade && can_guard(p2_state_i, p2_block_i);
    assign p1_blocked = p2_conn && !trade && can_guard(p1_state_i, p1_block_i);
    assign p1_dmg     = (p1_state_i == 4'd4) ? DMG_BASIC : DMG_DIR;
    assign p2_dmg     = (p2_state_i == 4'd4) ? DMG_BASIC : DMG_DIR;
    assign p2_hp_hit  = (p1_conn && !p2_blocked) ? sat_sub(p2_hp_q, p1_dmg) : p2_hp_q;
    assign p1_hp_hit  = (p2_conn && !p1_blocked) ? sat_sub(p1_hp_q, p2_dmg) : p1_hp_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        winner_d = winner_q;
        p1_hp_d  = p1_hp_hit;
        p2_hp_d  = p2_hp_hit;

        p1_load_d = p2_conn;
        p1_blk_d  = p1_blocked;
        p1_frm_d  = p2_conn ? (p1_blocked ? BLOCKSTUN_FRAMES : HITSTUN_FRAMES) : 5'd0;
        p2_load_d = p1_conn;
        p2_blk_d  = p2_blocked;
        p2_frm_d  = p1_conn ? (p2_blocked ? BLOCKSTUN_FRAMES : HITSTUN_FRAMES) : 5'd0;

        p1_hit_d = p1_hit_q;
        p2_hit_d = p2_hit_q;
        if (frame_tick_i && !is_attack(p1_state_i)) p1_hit_d = 1'b0;
        if (frame_tick_i && !is_attack(p2_state_i)) p2_hit_d = 1'b0;
        if (p1_conn) p1_hit_d = 1'b1;
        if (p2_conn) p2_hit_d = 1'b1;

        case (state_q)
            ST_WAIT: begin
                if (start_i) begin
                    state_d  = ST_COUNTDOWN;
                    cnt_d    = 8'd0;
                    p1_hp_d  = HEALTH_MAX;
                    p2_hp_d  = HEALTH_MAX;
                    timer_d  = ROUND_SECONDS;
                    winner_d = 2'b00;
                end
            end
            ST_COUNTDOWN: begin
                if (frame_tick_i) begin
                    if (cnt_q == CD_LAST) begin
                        state_d = ST_FIGHT;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_FIGHT: begin
                if (frame_tick_i) begin
                    if (cnt_q == SEC_LAST) begin
                        cnt_d = 8'd0;
                        if (timer_q != 7'd0) timer_d = timer_q - 7'd1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    // KO beats time-up when both happen on the same frame.
                    if ((p1_hp_hit == 7'd0) || (p2_hp_hit == 7'd0)) begin
                        state_d  = ST_KO;
                        cnt_d    = 8'd0;
                        winner_d = {p1_hp_hit == 7'd0, p2_hp_hit == 7'd0};
                    end else if (timer_d == 7'd0) begin
                        state_d  = ST_TIMEUP;
                        cnt_d    = 8'd0;
                        winner_d = (p1_hp_hit > p2_hp_hit) ? 2'b01 :
                                   (p2_hp_hit > p1_hp_hit) ? 2'b10 : 2'b11;
                    end
                end
            end
            ST_KO, ST_TIMEUP: begin
                if (frame_tick_i) begin
                    state_d = ST_RESULT;
                    cnt_d   = 8'd0;
                end
            end
            ST_RESULT: begin
                if (frame_tick_i) begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_WAIT;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_WAIT;
            cnt_q     <= 8'd0;
            p1_hp_q   <= HEALTH_MAX;
            p2_hp_q   <= HEALTH_MAX;
            timer_q   <= ROUND_SECONDS;
            winner_q  <= 2'b00;
            p1_hit_q  <= 1'b0;
            p2_hit_q  <= 1'b0;
            p1_load_q <= 1'b0;
            p2_load_q <= 1'b0;
            p1_blk_q  <= 1'b0;
            p2_blk_q  <= 1'b0;
            p1_frm_q  <= 5'd0;
            p2_frm_q  <= 5'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p1_hp_q   <= p1_hp_d;
            p2_hp_q   <= p2_hp_d;
            timer_q   <= timer_d;
            winner_q  <= winner_d;
            p1_hit_q  <= p1_hit_d;
            p2_hit_q  <= p2_hit_d;
            p1_load_q <= p1_load_d;
            p2_load_q <= p2_load_d;
            p1_blk_q  <= p1_blk_d;
            p2_blk_q  <= p2_blk_d;
            p1_frm_q  <= p1_frm_d;
            p2_frm_q  <= p2_frm_d;
        end
    end

    assign p1_stun_load_o   = p1_load_q;
    assign p2_stun_load_o   = p2_load_q;
    assign p1_stun_block_o  = p1_blk_q;
    assign p2_stun_block_o  = p2_blk_q;
    assign p1_stun_frames_o = p1_frm_q;
    assign p2_stun_frames_o = p2_frm_q;
    assign p1_health_o      = p1_hp_q;
    assign p2_health_o      = p2_hp_q;
    assign timer_sec_o      = timer_q;
    assign round_state_o    = state_q;
    assign winner_o         = winner_q;
    assign fight_en_o       = (state_q == ST_FIGHT);

endmodule

// File: doc/combat_referee.md
Name: combat_referee

Overview:
Frame-rate controller that arbitrates combat between the two character FSMs. On every frame tick it checks each attacker's active hitbox against the opponent's hurtbox and resolves hit, block or trade outcomes. It issues one-cycle stun-load commands back to the characters and owns both health counters. It also sequences the round (countdown, fight, KO/time-up, result hold) and gates player input through fight_en.

Parameters:
HEALTH_MAX, 7'd100, starting health per player
DMG_BASIC, 7'd10, damage for an unblocked basic attack
DMG_DIR, 7'd15, damage for an unblocked directional attack
HITSTUN_FRAMES, 5'd15, stun length loaded on a hit
BLOCKSTUN_FRAMES, 5'd8, stun length loaded on a block
COUNTDOWN_TICKS, 8'd180, frames spent in COUNTDOWN
ROUND_SECONDS, 7'd99, round timer start value
TICKS_PER_SEC, 6'd60, frames per timer second
HOLD_TICKS, 8'd120, frames spent in RESULT before returning to WAIT

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse, once per video frame
start  in  1  level; begins a round from WAIT
p1_x, p2_x  in  10 each  rendered sprite left edge (P1 faces right, P2 faces left)
p1_state, p2_state  in  4 each  character state codes: 0 idle, 1 fwd, 2 bwd, 3-5 basic startup/active/recovery, 6-8 dir startup/active/recovery, 9 hitstun, 10 blockstun
p1_block, p2_block  in  1 each  defender is holding block (derived at top level)
p1_stun_load, p2_stun_load  out  1 each  one-cycle command to enter stun
p1_stun_block, p2_stun_block  out  1 each  1 = blockstun, 0 = hitstun; valid with load
p1_stun_frames, p2_stun_frames  out  5 each  frame count to load; valid with load
p1_health, p2_health  out  7 each  current health
timer_sec  out  7  seconds remaining
round_state  out  3  0 WAIT, 1 COUNTDOWN, 2 FIGHT, 3 KO, 4 TIMEUP, 5 RESULT
winner  out  2  00 none, 01 P1, 10 P2, 11 draw
fight_en  out  1  high only in FIGHT; character inputs are ANDed with it

Behaviour:
- Reset values: health = HEALTH_MAX; timer_sec = ROUND_SECONDS; round_state = WAIT; winner = 00; all load/block/frames = 0; fight_en = 0; internal counters and hit latches = 0.
- All state updates happen on a clk edge with frame_tick = 1. The only exception is WAIT->COUNTDOWN, which is taken on any cycle start = 1.
- stun_load is high for exactly the cycle after the evaluating tick, then 0.
- Geometry uses 11-bit unsigned arithmetic, no wrap:
  - P1 hitbox is [p1_x+45, p1_x+58); P2 hitbox is [p2_x+6, p2_x+19).
  - Hurtbox for either player is [x+20, x+44).
  - Intervals [a,b) and [c,d) overlap iff a<d and c<b.
- Connect condition: attacker state is 4 or 7, the hitbox overlaps the defender's hurtbox, and the attacker's hit latch is clear.
  - On connect, set the attacker's hit latch.
  - The latch clears on any tick where the attacker state is not 4 and not 7, so each attack hits at most once.
- Block condition: defender block = 1 and defender state is in {0,1,2,10}.
  - Blocked: stun_block = 1, frames = BLOCKSTUN_FRAMES, no damage.
  - Unblocked: stun_block = 0, frames = HITSTUN_FRAMES.
  - Damage is DMG_BASIC for state 4 and DMG_DIR for state 7. Health saturates at 0 and never wraps.
- Trade: both players connect on the same tick. Both get hitstun and both take damage, regardless of block.
- Hits are evaluated only in FIGHT. In all other states the latches still clear per the rule above, but no loads are issued.
- Round FSM:
  - WAIT: on start, reload health and timer_sec, clear winner, enter COUNTDOWN.
  - COUNTDOWN: after COUNTDOWN_TICKS ticks, enter FIGHT.
  - FIGHT: timer_sec decrements every TICKS_PER_SEC ticks.
  - FIGHT exit uses post-damage health on the same tick. If either health is 0, go to KO; else if timer_sec reaches 0, go to TIMEUP.
  - KO winner: the player with nonzero health; both 0 gives 11.
  - TIMEUP winner: higher health; equal gives 11.
  - KO/TIMEUP: winner is latched on entry; move to RESULT on the next tick.
  - RESULT: after HOLD_TICKS ticks, return to WAIT. Health, timer and winner are held until the next start.
- The per-second and countdown counters reset on every state entry.
- Reset mid-round returns everything to reset values immediately, including a pending stun_load.

Test Plan:
- Reset, then start, then 180 ticks -> round_state 1 then 2; fight_en rises on the 180th tick; timer_sec = 99.
- FIGHT, p1_x = 100, p2_x = 130, p1_state = 4 for 2 ticks, p2 idle, no block -> exactly one p2_stun_load, frames 15, block 0; p2_health 90.
- Same setup with p2_block = 1 and p2_state = 0 -> p2_stun_load with block 1, frames 8; p2_health stays 100.
- p1_state = 7 and p2_state = 4, mutually overlapping (p1_x = 100, p2_x = 110) -> both loads on the same tick; p1_health 90, p2_health 85.
- p2_health 5, unblocked basic hit -> p2_health 0, round_state 3 then 5, winner 01; fight_en 0; returns to WAIT after 120 ticks.
- FIGHT with no hits for 99×60 ticks -> timer_sec reaches 0, TIMEUP, winner 11; assert rst mid-FIGHT -> health 100, round_state 0, loads 0.
